// File: rtl/memwb_stage.sv
// -----------------------------------------------------------------------------
// memwb_stage -- MEM/WB pipeline register with valid tracking, stall and flush.
//
// Latches the MEM-stage ALU result, load data, destination register and the
// write-back controls. From that registered state it drives the register-file
// write port (wbData/wbEnable) and two WB-stage forwarding match flags.
// Priority of control on each rising Clock edge: Reset > flush > stall > load.
//
// Optional feature macro: RETIRE_COUNT_EN
//   When defined, adds the retireCount output. It counts instructions leaving
//   the WB slot and wraps from all-ones to zero.
//
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   stall, flush            hold the stage / load a bubble (flush wins)
//   validIn                 MEM slot holds a real instruction
//   saidaALU, dataMEM       ALU result and load data from MEM
//   registradorDestinoData  destination register specifier
//   WB                      bit0 = RegWrite, bit1 = MemToReg
//   srcRegA, srcRegB        EX-stage source specifiers for the forwarding compare
//   validOut                WB slot holds a real instruction
//   saidaALUwb, saidaMEM    registered ALU result / memory data
//   saidaDestinoData        registered destination register
//   registradorEscrita      registered RegWrite, qualified by valid
//   registradorMEM          registered MemToReg, qualified by valid
//   wbData, wbEnable        register-file write data and write enable
//   fwdHitA, fwdHitB        WB result must be forwarded to operand A / B
//   retireCount             retired instruction count (RETIRE_COUNT_EN only)
// -----------------------------------------------------------------------------
module memwb_stage #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter bit          ZERO_REG_PROTECT = 1'b1,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      validIn,
  input  logic [DATA_WIDTH-1:0]     saidaALU,
  input  logic [DATA_WIDTH-1:0]     dataMEM,
  input  logic [REG_ADDR_WIDTH-1:0] registradorDestinoData,
  input  logic [1:0]                WB,
  input  logic [REG_ADDR_WIDTH-1:0] srcRegA,
  input  logic [REG_ADDR_WIDTH-1:0] srcRegB,
  output logic                      validOut,
  output logic [DATA_WIDTH-1:0]     saidaALUwb,
  output logic [DATA_WIDTH-1:0]     saidaMEM,
  output logic [REG_ADDR_WIDTH-1:0] saidaDestinoData,
  output logic                      registradorEscrita,
  output logic                      registradorMEM,
  output logic [DATA_WIDTH-1:0]     wbData,
  output logic                      wbEnable,
  output logic                      fwdHitA,
  output logic                      fwdHitB
`ifdef RETIRE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      retireCount
`endif
);

  // A write to register 0 is dropped only when protection is enabled.
  function automatic logic dest_blocked(input logic [REG_ADDR_WIDTH-1:0] dest);
    return ZERO_REG_PROTECT && (dest == {REG_ADDR_WIDTH{1'b0}});
  endfunction

  logic                      valid_q,    valid_d;
  logic [DATA_WIDTH-1:0]     alu_q,      alu_d;
  logic [DATA_WIDTH-1:0]     mem_q,      mem_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q,     dest_d;
  logic                      regwr_q,    regwr_d;
  logic                      memtoreg_q, memtoreg_d;
  logic                      wb_en_s;

  // Next-state selection: flush > stall > load (Reset is applied in the flop).
  always_comb begin
    valid_d    = valid_q;
    alu_d      = alu_q;
    mem_d      = mem_q;
    dest_d     = dest_q;
    regwr_d    = regwr_q;
    memtoreg_d = memtoreg_q;
    if (flush) begin
      valid_d    = 1'b0;
      alu_d      = {DATA_WIDTH{1'b0}};
      mem_d      = {DATA_WIDTH{1'b0}};
      dest_d     = {REG_ADDR_WIDTH{1'b0}};
      regwr_d    = 1'b0;
      memtoreg_d = 1'b0;
    end else if (stall) begin
      valid_d    = valid_q;
      alu_d      = alu_q;
      mem_d      = mem_q;
      dest_d     = dest_q;
      regwr_d    = regwr_q;
      memtoreg_d = memtoreg_q;
    end else begin
      // Data and destination load unconditionally; controls are gated by
      // validIn so a bubble can never write the register file.
      valid_d    = validIn;
      alu_d      = saidaALU;
      mem_d      = dataMEM;
      dest_d     = registradorDestinoData;
      regwr_d    = WB[0] & validIn;
      memtoreg_d = WB[1] & validIn;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q    <= 1'b0;
      alu_q      <= {DATA_WIDTH{1'b0}};
      mem_q      <= {DATA_WIDTH{1'b0}};
      dest_q     <= {REG_ADDR_WIDTH{1'b0}};
      regwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      mem_q      <= mem_d;
      dest_q     <= dest_d;
      regwr_q    <= regwr_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  // Write-back port and forwarding flags, from registered state only
  // (apart from the srcReg compare operands).
  always_comb begin
    wb_en_s = valid_q & regwr_q & ~dest_blocked(dest_q);
    if (memtoreg_q) begin
      wbData = mem_q;
    end else begin
      wbData = alu_q;
    end
    fwdHitA = wb_en_s & (dest_q == srcRegA);
    fwdHitB = wb_en_s & (dest_q == srcRegB);
  end

  assign validOut           = valid_q;
  assign saidaALUwb         = alu_q;
  assign saidaMEM           = mem_q;
  assign saidaDestinoData   = dest_q;
  assign registradorEscrita = regwr_q;
  assign registradorMEM     = memtoreg_q;
  assign wbEnable           = wb_en_s;

`ifdef RETIRE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire_s;

  // An instruction leaves WB when the slot is valid and it is either replaced
  // (no stall) or flushed away; wrap-around is the natural modulo add.
  always_comb begin
    retire_s = valid_q & (~stall | flush);
    if (retire_s) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retire counter register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retireCount = cnt_q;
`endif

endmodule

// File: doc/memwb_stage.md
Name: memwb_stage

Overview:
- Parametrised MEM/WB pipeline register with valid tracking, stall and flush control.
- Latches the ALU result, memory data, destination register and write-back controls from the MEM stage.
- Drives the register-file write port: write data mux and write enable.
- Provides WB-stage forwarding match flags for two source-register operands.

Parameters:
DATA_WIDTH, 32, width of the ALU result, memory data and write-back data
REG_ADDR_WIDTH, 5, width of register specifiers
ZERO_REG_PROTECT, 1, 1 = writes to register 0 are suppressed; 0 = register 0 is writable
CNT_WIDTH, 32, width of the retire counter (used only with the optional feature)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
stall  in  1  hold all stage contents this cycle
flush  in  1  load a bubble instead of the incoming instruction
validIn  in  1  the MEM-stage slot holds a real instruction
saidaALU  in  DATA_WIDTH  ALU result from MEM
dataMEM  in  DATA_WIDTH  load data from memory
registradorDestinoData  in  REG_ADDR_WIDTH  destination register
WB  in  2  bit0 = RegWrite, bit1 = MemToReg
srcRegA  in  REG_ADDR_WIDTH  EX-stage source A specifier, used for forwarding compare
srcRegB  in  REG_ADDR_WIDTH  EX-stage source B specifier
validOut  out  1  the WB slot holds a real instruction
saidaALUwb  out  DATA_WIDTH  registered ALU result
saidaMEM  out  DATA_WIDTH  registered memory data
saidaDestinoData  out  REG_ADDR_WIDTH  registered destination register
registradorEscrita  out  1  registered RegWrite, qualified by valid
registradorMEM  out  1  registered MemToReg
wbData  out  DATA_WIDTH  write-back data
wbEnable  out  1  register-file write enable
fwdHitA  out  1  WB result must be forwarded to operand A
fwdHitB  out  1  WB result must be forwarded to operand B
retireCount  out  CNT_WIDTH  number of retired instructions (present only with RETIRE_COUNT_EN)

Behaviour:
- All state updates on the rising edge of Clock. Latency is 1 cycle from the input ports to the registered outputs.
- Priority, highest first: Reset > flush > stall > load.
- Reset: every registered output is cleared to 0, i.e. validOut, saidaALUwb, saidaMEM, saidaDestinoData, registradorEscrita, registradorMEM, and retireCount.
- flush=1:
  - validOut, registradorEscrita and registradorMEM are cleared to 0.
  - The data registers and saidaDestinoData are cleared to 0.
  - flush wins over a simultaneous stall.
- stall=1 with flush=0: all registers hold their values. A repeated stall holds indefinitely.
- Load, when Reset, flush and stall are all 0:
  - validOut <= validIn.
  - Data and destination registers load their inputs unconditionally.
  - registradorEscrita <= WB[0] & validIn.
  - registradorMEM <= WB[1] & validIn.
- Combinational outputs, derived from the registered state only:
  - wbData = registradorMEM ? saidaMEM : saidaALUwb.
  - wbEnable = validOut & registradorEscrita & ~(ZERO_REG_PROTECT & (saidaDestinoData == 0)).
  - fwdHitA = wbEnable & (saidaDestinoData == srcRegA). fwdHitB is the same, compared against srcRegB.
- The forwarding flags are purely combinational from srcRegA/srcRegB. There is no path from any other input to any output in the same cycle.
- Reset asserted mid-stall: the stage is cleared; the held instruction is lost.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- Defined:
  - The retireCount port and a CNT_WIDTH counter exist.
  - On each edge with Reset=0 and validOut=1 and (stall=0 or flush=1), the counter increments by 1. This is the instruction leaving WB.
  - The counter wraps from all-ones to 0.
  - Reset clears the counter.
- Undefined: neither the port nor the counter exists; all other behaviour is identical.

Test Plan:
1. Reset=1 for 2 cycles with all inputs nonzero -> every output is 0. wbEnable=0, fwdHitA=0, fwdHitB=0.
2. Load validIn=1, saidaALU=0x0000_1234, dataMEM=0xDEAD_BEEF, dest=7, WB=2'b11 -> next cycle:
   - wbData=0xDEAD_BEEF, wbEnable=1.
   - With srcRegA=7: fwdHitA=1. With srcRegB=3: fwdHitB=0.
   - After changing WB to 2'b01 and loading: wbData=0x0000_1234.
3. Load dest=0, WB=2'b01, valid=1:
   - ZERO_REG_PROTECT=1 -> wbEnable=0, fwdHitA=0 with srcRegA=0.
   - ZERO_REG_PROTECT=0 -> wbEnable=1.
4. Load instruction A, then hold stall=1 for 3 cycles while the inputs change to B -> outputs stay at A for all 3 cycles. Deassert stall -> B appears the following cycle.
5. Assert stall=1 and flush=1 together with valid A in WB -> next cycle validOut=0, wbEnable=0, registradorEscrita=0. With RETIRE_COUNT_EN, the count increments by 1.
6. RETIRE_COUNT_EN, CNT_WIDTH=4:
   - Stream 17 valid instructions with no stall -> retireCount wraps and reads 1 after the 17th retire.
   - Invalid slots (validIn=0) do not increment the count.
